// File: rtl/grid_state_engine.sv
// Sequential owner of the Life board: loads rows from the host, advances generations
// from the external cell grid's next-state vector, and reads rows back out.
module grid_state_engine #(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 8,
  parameter int GEN_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_op,
  input  logic [7:0]                        cmd_arg,
  input  logic                              row_in_valid,
  output logic                              row_in_ready,
  input  logic [GRID_WIDTH-1:0]             row_in,
  output logic                              row_out_valid,
  input  logic                              row_out_ready,
  output logic [GRID_WIDTH-1:0]             row_out,
  output logic                              row_out_last,
  output logic [GRID_WIDTH*GRID_HEIGHT-1:0] grid_state,
  input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] next_state,
  output logic [GEN_WIDTH-1:0]              generation,
  output logic                              still,
  output logic                              busy
);

  localparam int IDX_W = (GRID_HEIGHT > 1) ? $clog2(GRID_HEIGHT) : 1;
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(GRID_HEIGHT - 1);
  localparam logic [GEN_WIDTH-1:0] GEN_ONE = GEN_WIDTH'(1);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_STEP = 2'b10,
    ST_READ = 2'b11
  } state_t;

  state_t                              state_r;
  logic [GRID_WIDTH*GRID_HEIGHT-1:0]   grid_r;
  logic [IDX_W-1:0]                    row_idx_r;
  logic [7:0]                          count_r;
  logic [GEN_WIDTH-1:0]                gen_r;
  logic                                still_r;
  logic                                cmd_ready_r;
  logic                                row_in_ready_r;
  logic                                row_out_valid_r;
  logic [GRID_WIDTH-1:0]               row_out_r;
  logic                                row_out_last_r;
  logic                                busy_r;
  logic [IDX_W-1:0]                    row_idx_inc_s;

  function automatic logic [GRID_WIDTH-1:0] row_of(
    input logic [GRID_WIDTH*GRID_HEIGHT-1:0] g,
    input logic [IDX_W-1:0]                  idx
  );
    return g[GRID_WIDTH*idx +: GRID_WIDTH];
  endfunction

  assign row_idx_inc_s = row_idx_r + IDX_ONE;

  // Command FSM with board, counters and handshake outputs all held in registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      grid_r          <= '0;
      row_idx_r       <= IDX_ZERO;
      count_r         <= 8'd0;
      gen_r           <= '0;
      still_r         <= 1'b0;
      cmd_ready_r     <= 1'b1;
      row_in_ready_r  <= 1'b0;
      row_out_valid_r <= 1'b0;
      row_out_r       <= '0;
      row_out_last_r  <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: begin
                state_r        <= ST_LOAD;
                row_idx_r      <= IDX_ZERO;
                cmd_ready_r    <= 1'b0;
                row_in_ready_r <= 1'b1;
                busy_r         <= 1'b1;
              end
              OP_STEP: begin
                // A zero-length step is accepted but leaves everything untouched.
                if (cmd_arg != 8'd0) begin
                  state_r     <= ST_STEP;
                  count_r     <= cmd_arg;
                  cmd_ready_r <= 1'b0;
                  busy_r      <= 1'b1;
                end
              end
              OP_READ: begin
                state_r         <= ST_READ;
                row_idx_r       <= IDX_ZERO;
                row_out_valid_r <= 1'b1;
                row_out_r       <= row_of(grid_r, IDX_ZERO);
                row_out_last_r  <= (IDX_ZERO == IDX_LAST);
                cmd_ready_r     <= 1'b0;
                busy_r          <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          if (row_in_valid) begin
            grid_r[GRID_WIDTH*row_idx_r +: GRID_WIDTH] <= row_in;
            if (row_idx_r == IDX_LAST) begin
              state_r        <= ST_IDLE;
              row_idx_r      <= IDX_ZERO;
              gen_r          <= '0;
              still_r        <= 1'b0;
              row_in_ready_r <= 1'b0;
              cmd_ready_r    <= 1'b1;
              busy_r         <= 1'b0;
            end else begin
              row_idx_r <= row_idx_inc_s;
            end
          end
        end
        ST_STEP: begin
          grid_r  <= next_state;
          gen_r   <= gen_r + GEN_ONE;
          still_r <= (next_state == grid_r);
          count_r <= count_r - 8'd1;
          if (count_r == 8'd1) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        ST_READ: begin
          // Row data only advances on a completed transfer, so it holds under backpressure.
          if (row_out_ready) begin
            if (row_out_last_r) begin
              state_r         <= ST_IDLE;
              row_idx_r       <= IDX_ZERO;
              row_out_valid_r <= 1'b0;
              row_out_r       <= '0;
              row_out_last_r  <= 1'b0;
              cmd_ready_r     <= 1'b1;
              busy_r          <= 1'b0;
            end else begin
              row_idx_r      <= row_idx_inc_s;
              row_out_r      <= row_of(grid_r, row_idx_inc_s);
              row_out_last_r <= (row_idx_inc_s == IDX_LAST);
            end
          end
        end
        default: begin
          state_r         <= ST_IDLE;
          row_idx_r       <= IDX_ZERO;
          cmd_ready_r     <= 1'b1;
          row_in_ready_r  <= 1'b0;
          row_out_valid_r <= 1'b0;
          row_out_last_r  <= 1'b0;
          busy_r          <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign row_in_ready  = row_in_ready_r;
  assign row_out_valid = row_out_valid_r;
  assign row_out       = row_out_r;
  assign row_out_last  = row_out_last_r;
  assign grid_state    = grid_r;
  assign generation    = gen_r;
  assign still         = still_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_grid_state_engine.sv
// Scoreboard bench for grid_state_engine; the bench plays the role of the Life cell grid.
module tb_grid_state_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_arg = 8'd0;
  logic        row_in_valid = 1'b0;
  logic [7:0]  row_in = 8'd0;
  logic        row_out_ready = 1'b0;

  logic        cmd_ready, row_in_ready, row_out_valid, row_out_last, still, busy;
  logic [7:0]  row_out;
  logic [63:0] grid_state, next_state;
  logic [15:0] generation;

  logic        cmd_ready_w, row_in_ready_w, row_out_valid_w, row_out_last_w, still_w, busy_w;
  logic [7:0]  row_out_w;
  logic [63:0] grid_state_w, next_state_w;
  logic [3:0]  generation_w;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [8:0] exp_q[$];

  localparam logic [63:0] BLINKER_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINKER_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK     = 64'h0000_0018_1800_0000;

  always #5 clk = ~clk;

  grid_state_engine #(.GRID_WIDTH(8), .GRID_HEIGHT(8), .GEN_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .row_in_valid(row_in_valid),
    .row_in_ready(row_in_ready), .row_in(row_in), .row_out_valid(row_out_valid),
    .row_out_ready(row_out_ready), .row_out(row_out), .row_out_last(row_out_last),
    .grid_state(grid_state), .next_state(next_state), .generation(generation),
    .still(still), .busy(busy)
  );

  grid_state_engine #(.GRID_WIDTH(8), .GRID_HEIGHT(8), .GEN_WIDTH(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .row_in_valid(row_in_valid),
    .row_in_ready(row_in_ready_w), .row_in(row_in), .row_out_valid(row_out_valid_w),
    .row_out_ready(row_out_ready), .row_out(row_out_w), .row_out_last(row_out_last_w),
    .grid_state(grid_state_w), .next_state(next_state_w), .generation(generation_w),
    .still(still_w), .busy(busy_w)
  );

  // Conway's rules with dead cells beyond the board edge.
  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] r;
    int n;
    r = 64'd0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dx != 0 || dy != 0) && (x+dx) >= 0 && (x+dx) < 8 && (y+dy) >= 0 && (y+dy) < 8)
              n += int'(g[8*(y+dy) + (x+dx)]);
        r[8*y + x] = (n == 3) || (g[8*y + x] && n == 2);
      end
    end
    return r;
  endfunction

  assign next_state   = life(grid_state);
  assign next_state_w = life(grid_state_w);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] arg);
    int cyc = 0;
    while (!cmd_ready && cyc < 100) begin
      tick();
      cyc++;
    end
    total_cnt++;
    if (!cmd_ready) $display("FAIL cmd_ready_timeout: got %b want 1", cmd_ready);
    else pass_cnt++;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    tick();
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_arg = 8'd0;
  endtask

  task automatic load_board(input logic [63:0] g, input bit gaps, input int nrows);
    int cyc;
    do_cmd(2'b00, 8'd0);
    for (int i = 0; i < nrows; i++) begin
      if (gaps && (i % 2 == 1)) begin
        row_in_valid = 1'b0;
        tick();
        tick();
      end
      if (gaps && i == 7) begin
        total_cnt++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1)
          $display("FAIL load_incomplete: cmd_ready=%b busy=%b want 0/1", cmd_ready, busy);
        else pass_cnt++;
      end
      row_in_valid = 1'b1;
      row_in = g[8*i +: 8];
      cyc = 0;
      while (!row_in_ready && cyc < 20) begin
        tick();
        cyc++;
      end
      total_cnt++;
      if (!row_in_ready) $display("FAIL row_in_ready_timeout: row %0d got %b want 1", i, row_in_ready);
      else pass_cnt++;
      tick();
    end
    row_in_valid = 1'b0;
    row_in = 8'd0;
  endtask

  task automatic read_board(input logic [63:0] exp_grid, input bit stall);
    int n = 0;
    int cyc = 0;
    int k = 0;
    logic [3:0] pat = 4'b1001;
    logic       prev_stalled = 1'b0;
    logic [7:0] prev_row = 8'd0;
    logic       prev_last = 1'b0;
    logic [8:0] e;
    do_cmd(2'b10, 8'd0);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), exp_grid[8*i +: 8]});
    while (n < 8 && cyc < 200) begin
      row_out_ready = stall ? pat[k % 4] : 1'b1;
      k++;
      if (row_out_valid && prev_stalled) begin
        total_cnt++;
        if (row_out !== prev_row || row_out_last !== prev_last)
          $display("FAIL read_hold: row %h last %b want %h %b", row_out, row_out_last, prev_row, prev_last);
        else pass_cnt++;
      end
      if (row_out_valid && row_out_ready) begin
        e = exp_q.pop_front();
        total_cnt++;
        if ({row_out_last, row_out} !== e)
          $display("FAIL read_row%0d: last/row %b/%h want %b/%h", n, row_out_last, row_out, e[8], e[7:0]);
        else pass_cnt++;
        n++;
        prev_stalled = 1'b0;
      end else begin
        prev_stalled = row_out_valid;
      end
      prev_row = row_out;
      prev_last = row_out_last;
      tick();
      cyc++;
    end
    row_out_ready = 1'b0;
    total_cnt++;
    if (n != 8 || row_out_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL read_done: beats %0d valid %b ready %b busy %b want 8 0 1 0", n, row_out_valid, cmd_ready, busy);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    total_cnt++;
    if (cmd_ready !== 1'b1 || row_in_ready !== 1'b0 || row_out_valid !== 1'b0 || row_out_last !== 1'b0 ||
        busy !== 1'b0 || grid_state !== 64'd0 || generation !== 16'd0 || still !== 1'b0 || generation_w !== 4'd0)
      $display("FAIL %s: rdy %b in %b out %b last %b busy %b grid %h gen %0d still %b want 1 0 0 0 0 0 0 0",
               tag, cmd_ready, row_in_ready, row_out_valid, row_out_last, busy, grid_state, generation, still);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_values("reset_state");
  endtask

  task automatic test_blinker();
    load_board(BLINKER_H, 1'b0, 8);
    total_cnt++;
    if (grid_state !== BLINKER_H || generation !== 16'd0)
      $display("FAIL blinker_load: grid %h gen %0d want %h 0", grid_state, generation, BLINKER_H);
    else pass_cnt++;
    do_cmd(2'b01, 8'd1);
    tick();
    read_board(BLINKER_V, 1'b0);
    total_cnt++;
    if (generation !== 16'd1 || still !== 1'b0)
      $display("FAIL blinker_gen: gen %0d still %b want 1 0", generation, still);
    else pass_cnt++;
  endtask

  task automatic test_blinker_period();
    do_cmd(2'b01, 8'd1);
    read_board(BLINKER_H, 1'b0);
    total_cnt++;
    if (generation !== 16'd2) $display("FAIL blinker_gen2: gen %0d want 2", generation);
    else pass_cnt++;
    do_cmd(2'b01, 8'd0);
    total_cnt++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || generation !== 16'd2 || grid_state !== BLINKER_H)
      $display("FAIL step_zero: ready %b busy %b gen %0d grid %h want 1 0 2 %h",
               cmd_ready, busy, generation, grid_state, BLINKER_H);
    else pass_cnt++;
    do_cmd(2'b11, 8'd7);
    total_cnt++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || generation !== 16'd2)
      $display("FAIL reserved_op: ready %b busy %b gen %0d want 1 0 2", cmd_ready, busy, generation);
    else pass_cnt++;
  endtask

  task automatic test_still_life();
    int busy_cycles = 0;
    load_board(BLOCK, 1'b0, 8);
    do_cmd(2'b01, 8'd5);
    while (busy && busy_cycles < 50) begin
      busy_cycles++;
      tick();
    end
    total_cnt++;
    if (busy_cycles != 5) $display("FAIL step5_busy: %0d cycles want 5", busy_cycles);
    else pass_cnt++;
    total_cnt++;
    if (grid_state !== BLOCK || still !== 1'b1 || generation !== 16'd5)
      $display("FAIL still_life: grid %h still %b gen %0d want %h 1 5", grid_state, still, generation, BLOCK);
    else pass_cnt++;
  endtask

  task automatic test_read_backpressure();
    read_board(BLOCK, 1'b1);
    total_cnt++;
    if (grid_state !== BLOCK) $display("FAIL read_keeps_grid: grid %h want %h", grid_state, BLOCK);
    else pass_cnt++;
  endtask

  task automatic test_load_stall_reset();
    load_board(BLINKER_V, 1'b1, 8);
    total_cnt++;
    if (grid_state !== BLINKER_V || cmd_ready !== 1'b1 || generation !== 16'd0 || still !== 1'b0)
      $display("FAIL load_gaps: grid %h ready %b gen %0d still %b want %h 1 0 0",
               grid_state, cmd_ready, generation, still, BLINKER_V);
    else pass_cnt++;
    load_board(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_load");
    tick();
    rst_n = 1'b1;
    tick();
    read_board(64'd0, 1'b0);
  endtask

  task automatic test_wrap();
    load_board(BLINKER_H, 1'b0, 8);
    do_cmd(2'b01, 8'd17);
    for (int i = 0; i < 17; i++) tick();
    total_cnt++;
    if (generation_w !== 4'd1 || generation !== 16'd17 || grid_state_w !== BLINKER_V)
      $display("FAIL gen_wrap: gen4 %0d gen16 %0d grid %h want 1 17 %h", generation_w, generation, grid_state_w, BLINKER_V);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_blinker_period();
    test_still_life();
    test_read_backpressure();
    test_load_stall_reset();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
